// File: rtl/pipeline_redirect_ctrl.sv
// EX-stage redirect consumer: PC redirect, pipeline flush, fetch masking, load-use stall.
// Optional perf counters and protocol-error flag under REDIRECT_PERF_CNT_EN.
module pipeline_redirect_ctrl #(
    parameter int FETCH_LAT = 1,
    parameter int PC_W      = 32
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            ControlHazard,
    input  logic [PC_W-1:0] EXTargetPc,
    input  logic            DataHazard,
    output logic            RedirectValid,
    output logic [PC_W-1:0] RedirectPc,
    output logic            FlushIFID,
    output logic            FlushIDEX,
    output logic            StallPC,
    output logic            StallIFID,
    output logic            FetchValid,
    output logic            Draining
`ifdef REDIRECT_PERF_CNT_EN
    ,
    output logic [31:0]     FlushCount,
    output logic [31:0]     StallCount,
    output logic [0:0]      ProtoErr
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [1:0] LAT = 2'(FETCH_LAT);

    state_t     state;
    logic [1:0] drain_cnt;

    always_comb begin
        RedirectValid = 1'b0;
        RedirectPc    = '0;
        FlushIFID     = 1'b0;
        FlushIDEX     = 1'b0;
        StallPC       = 1'b0;
        StallIFID     = 1'b0;
        FetchValid    = 1'b0;
        Draining      = 1'b0;
        if (!cpu_rst) begin
            unique case (state)
                DRAIN: begin
                    // Stale IROM data is turned into a bubble
                    FlushIFID = 1'b1;
                    Draining  = 1'b1;
                end
                default: begin
                    FetchValid = 1'b1;
                    if (ControlHazard) begin
                        RedirectValid = 1'b1;
                        RedirectPc    = EXTargetPc;
                        FlushIFID     = 1'b1;
                        FlushIDEX     = 1'b1;
                    end else if (DataHazard) begin
                        StallPC   = 1'b1;
                        StallIFID = 1'b1;
                        FlushIDEX = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state     <= (LAT == 2'd0) ? RUN : DRAIN;
            drain_cnt <= LAT;
        end else begin
            unique case (state)
                DRAIN: begin
                    drain_cnt <= drain_cnt - 2'd1;
                    if (drain_cnt == 2'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    if (ControlHazard && LAT != 2'd0) begin
                        state     <= DRAIN;
                        drain_cnt <= LAT;
                    end
                end
            endcase
        end
    end

`ifdef REDIRECT_PERF_CNT_EN
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            FlushCount <= '0;
            StallCount <= '0;
            ProtoErr   <= '0;
        end else begin
            if (RedirectValid && FlushCount != 32'hFFFF_FFFF) begin
                FlushCount <= FlushCount + 32'd1;
            end
            if (StallPC && StallCount != 32'hFFFF_FFFF) begin
                StallCount <= StallCount + 32'd1;
            end
            // EX should hold a bubble while draining
            if (Draining && ControlHazard) begin
                ProtoErr <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_redirect_ctrl.sv
// Bench for pipeline_redirect_ctrl at FETCH_LAT=1 and FETCH_LAT=3.
// Build with REDIRECT_PERF_CNT_EN to also check the perf counters.
module tb_pipeline_redirect_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        ch;
    logic        dh;
    logic [31:0] tgt;

    logic        rv0, fi0, fx0, sp0, si0, fv0, dr0;
    logic        rv1, fi1, fx1, sp1, si1, fv1, dr1;
    logic [31:0] pc0, pc1;
`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] fc0, sc0, fc1, sc1;
    logic [0:0]  pe0, pe1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 cpu_clk = ~cpu_clk;

    pipeline_redirect_ctrl #(.FETCH_LAT(1), .PC_W(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .ControlHazard(ch), .EXTargetPc(tgt), .DataHazard(dh),
        .RedirectValid(rv0), .RedirectPc(pc0),
        .FlushIFID(fi0), .FlushIDEX(fx0),
        .StallPC(sp0), .StallIFID(si0),
        .FetchValid(fv0), .Draining(dr0)
`ifdef REDIRECT_PERF_CNT_EN
        , .FlushCount(fc0), .StallCount(sc0), .ProtoErr(pe0)
`endif
    );

    pipeline_redirect_ctrl #(.FETCH_LAT(3), .PC_W(32)) dut3 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .ControlHazard(ch), .EXTargetPc(tgt), .DataHazard(dh),
        .RedirectValid(rv1), .RedirectPc(pc1),
        .FlushIFID(fi1), .FlushIDEX(fx1),
        .StallPC(sp1), .StallIFID(si1),
        .FetchValid(fv1), .Draining(dr1)
`ifdef REDIRECT_PERF_CNT_EN
        , .FlushCount(fc1), .StallCount(sc1), .ProtoErr(pe1)
`endif
    );

    // Model: remaining masked fetch cycles per instance, plus counters
    int          lat[2] = '{1, 3};
    int          mask[2];
    longint      m_flush[2];
    longint      m_stall[2];
    bit          m_proto[2];
    bit          known = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {RedirectValid, RedirectPc, FlushIFID, FlushIDEX, StallPC, StallIFID, FetchValid, Draining}
    function automatic logic [38:0] model_out(input int i);
        logic rv, fi, fx, sp, si, fv, dr;
        logic [31:0] pc;
        {rv, fi, fx, sp, si, fv, dr} = '0;
        pc = '0;
        if (!cpu_rst) begin
            if (mask[i] > 0) begin
                fi = 1'b1;
                dr = 1'b1;
            end else begin
                fv = 1'b1;
                if (ch) begin
                    rv = 1'b1; pc = tgt; fi = 1'b1; fx = 1'b1;
                end else if (dh) begin
                    sp = 1'b1; si = 1'b1; fx = 1'b1;
                end
            end
        end
        return {rv, pc, fi, fx, sp, si, fv, dr};
    endfunction

    always @(posedge cpu_clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [38:0] o;
            o = model_out(i);
            if (cpu_rst) begin
                mask[i]    = lat[i];
                m_flush[i] = 0;
                m_stall[i] = 0;
                m_proto[i] = 1'b0;
            end else begin
                if (o[38] && m_flush[i] < 64'hFFFF_FFFF) m_flush[i]++;
                if (o[4] && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
                if (mask[i] > 0) begin
                    if (ch) m_proto[i] = 1'b1;
                    mask[i]--;
                end else if (ch) begin
                    mask[i] = lat[i];
                end
            end
        end
        if (cpu_rst) known = 1'b1;
    end

    always @(negedge cpu_clk) begin
        if (known) begin
            check("out_lat1", 64'({rv0, pc0, fi0, fx0, sp0, si0, fv0, dr0}), 64'(model_out(0)));
            check("out_lat3", 64'({rv1, pc1, fi1, fx1, sp1, si1, fv1, dr1}), 64'(model_out(1)));
`ifdef REDIRECT_PERF_CNT_EN
            check("cnt_lat1", {fc0, sc0}, {m_flush[0][31:0], m_stall[0][31:0]});
            check("cnt_lat3", {fc1, sc1}, {m_flush[1][31:0], m_stall[1][31:0]});
            check("perr", 64'({pe0, pe1}), 64'({m_proto[0], m_proto[1]}));
`endif
        end
    end

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        cpu_rst = 1'b1; ch = 1'b0; dh = 1'b0; tgt = '0;
        // Reset: everything zero
        @(negedge cpu_clk);
        check("rst_zero_a", 64'({rv0, pc0, fi0, fx0, sp0, si0, fv0, dr0}), 64'd0);
        tick;
        @(negedge cpu_clk);
        check("rst_zero_b", 64'({rv1, pc1, fi1, fx1, sp1, si1, fv1, dr1}), 64'd0);
        tick;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        check("rst_drain", 64'({fv0, fi0, dr0}), 64'b011);
        tick;
        @(negedge cpu_clk);
        check("rst_run", 64'({fv0, fi0, dr0}), 64'b100);
        repeat (3) tick;

        // Redirect
        ch = 1'b1; tgt = 32'h0000_0040;
        @(negedge cpu_clk);
        check("redir_ctl", 64'({rv0, fi0, fx0, sp0, si0}), 64'b11100);
        check("redir_pc", 64'(pc0), 64'h40);
        tick;
        ch = 1'b0;
        @(negedge cpu_clk);
        check("redir_drain", 64'({dr0, fv0}), 64'b10);
        tick;
        @(negedge cpu_clk);
        check("redir_back", 64'({dr0, fv0}), 64'b01);
        tick;

        // Load-use stall, 2 cycles
        dh = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge cpu_clk);
            check("stall", 64'({sp0, si0, fx0, fi0, rv0}), 64'b11100);
            tick;
        end
        dh = 1'b0;

        // Control beats data
        ch = 1'b1; dh = 1'b1; tgt = 32'h0000_1000;
        @(negedge cpu_clk);
        check("prio", 64'({rv0, sp0, si0, fi0}), 64'b1001);
        check("prio_pc", 64'(pc0), 64'h1000);
        tick;
        ch = 1'b0; dh = 1'b0;
        repeat (4) tick;

        // FETCH_LAT=3, hazard on second drain cycle
        ch = 1'b1; tgt = 32'h0000_0200;
        @(negedge cpu_clk);
        check("l3_redir", 64'({rv1, dr1}), 64'b10);
        tick;
        ch = 1'b0;
        @(negedge cpu_clk);
        check("l3_d1", 64'({rv1, dr1, fv1}), 64'b010);
        tick;
        ch = 1'b1; tgt = 32'h0000_0300;
        @(negedge cpu_clk);
        check("l3_d2", 64'({rv1, dr1, fv1}), 64'b010);
        tick;
        ch = 1'b0;
        @(negedge cpu_clk);
        check("l3_d3", 64'({rv1, dr1, fv1}), 64'b010);
        tick;
        @(negedge cpu_clk);
        check("l3_run", 64'({rv1, dr1, fv1}), 64'b001);
`ifdef REDIRECT_PERF_CNT_EN
        check("l3_perr", 64'(pe1), 64'd1);
`endif
        tick;

`ifdef REDIRECT_PERF_CNT_EN
        // Counters: 5 redirects, 7 stalls, then clear
        cpu_rst = 1'b1;
        tick;
        cpu_rst = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            ch = 1'b1; tgt = 32'(k * 16);
            tick;
            ch = 1'b0;
            tick;
        end
        dh = 1'b1;
        repeat (7) tick;
        dh = 1'b0;
        @(negedge cpu_clk);
        check("cnt_flush", 64'(fc0), 64'd5);
        check("cnt_stall", 64'(sc0), 64'd7);
        tick;
        cpu_rst = 1'b1;
        tick;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        check("cnt_clear", 64'({fc0, sc0}), 64'd0);
        check("perr_clear", 64'({pe0, pe1}), 64'd0);
        tick;
`endif

        // Randomized traffic checked by the compare process
        for (int k = 0; k < 3000; k++) begin
            cpu_rst = ($urandom_range(0, 49) == 0);
            ch      = ($urandom_range(0, 3) == 0);
            dh      = ($urandom_range(0, 2) == 0);
            tgt     = $urandom;
            tick;
        end
        cpu_rst = 1'b0; ch = 1'b0; dh = 1'b0;
        @(negedge cpu_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
